// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//   Four-digit multiplexed seven-segment driver for a common-anode display.
//   A BCD value plus decimal points arrives over a valid/ready handshake into
//   a one-entry pending buffer. At the end of a frame the buffer moves into
//   the display register, so one frame never shows two values. Each digit
//   slot begins with a blank guard cycle to avoid ghosting between digits.
//
//   Optional feature: define SEG_LZB_EN to blank leading zeros on digits
//   3..1. Digit 0 is never blanked, and decimal points are still shown.
//
// Parameters
//   SCAN_DIV    S_clk cycles per digit slot (2 or more); cycle 0 is the guard.
//
// Ports
//   S_clk       clock, rising edge
//   Reset       asynchronous, active-high reset
//   in_valid    upstream offers value_in / dp_in
//   in_ready    pending buffer is empty
//   value_in    four BCD digits, [3:0] is digit 0 (rightmost)
//   dp_in       decimal point per digit, 1 = lit
//   Result      segments, active-low, {dp,g,f,e,d,c,b,a}
//   vcc_in      anode enables, active-low, bit d drives digit d
//   frame_done  one-cycle pulse after each completed 4-digit frame
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int SCAN_DIV = 4
) (
  input  logic        S_clk,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  output logic [7:0]  Result,
  output logic [3:0]  vcc_in,
  output logic        frame_done
);

  localparam int            CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  // BCD to active-low segments {g,f,e,d,c,b,a}; non-decimal codes show '-'.
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase
    return seg;
  endfunction

`ifdef SEG_LZB_EN
  // A digit is a leading zero when it and every higher digit are zero.
  function automatic logic lead_zero(input logic [15:0] val, input logic [1:0] idx);
    logic blank;
    case (idx)
      2'd3:    blank = (val[15:12] == 4'h0);
      2'd2:    blank = (val[15:8] == 8'h00);
      2'd1:    blank = (val[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
    return blank;
  endfunction
`endif

  logic [CW-1:0] scan_cnt_q,   scan_cnt_d;
  logic [1:0]    digit_idx_q,  digit_idx_d;
  logic [15:0]   disp_val_q,   disp_val_d;
  logic [3:0]    disp_dp_q,    disp_dp_d;
  logic [15:0]   pend_val_q,   pend_val_d;
  logic [3:0]    pend_dp_q,    pend_dp_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    result_q,     result_d;
  logic [3:0]    vcc_q,        vcc_d;
  logic          frame_done_q, frame_done_d;

  logic          scan_last_s;
  logic          frame_end_s;
  logic          accept_s;
  logic          swap_s;
  logic [3:0]    cur_bcd_s;
  logic          cur_dp_s;
  logic [6:0]    seg_s;

  // Slot and digit counters; digit_idx wraps 3 -> 0 through its 2-bit width.
  always_comb begin
    scan_last_s = (scan_cnt_q == SCAN_LAST);
    frame_end_s = scan_last_s && (digit_idx_q == 2'd3);
    if (scan_last_s) begin
      scan_cnt_d  = {CW{1'b0}};
      digit_idx_d = digit_idx_q + 2'd1;
    end else begin
      scan_cnt_d  = scan_cnt_q + CW'(1);
      digit_idx_d = digit_idx_q;
    end
  end

  // Pending buffer and frame-boundary swap. Accept and swap are mutually
  // exclusive (accept needs an empty buffer, swap a full one), so a value
  // taken on the frame-end cycle waits a whole frame.
  always_comb begin
    accept_s     = in_valid && !pend_valid_q;
    swap_s       = frame_end_s && pend_valid_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (accept_s) begin
      pend_val_d   = value_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end else if (swap_s) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Segment and anode pattern for the current slot, registered next edge.
  always_comb begin
    case (digit_idx_q)
      2'd0:    cur_bcd_s = disp_val_q[3:0];
      2'd1:    cur_bcd_s = disp_val_q[7:4];
      2'd2:    cur_bcd_s = disp_val_q[11:8];
      default: cur_bcd_s = disp_val_q[15:12];
    endcase
    cur_dp_s = disp_dp_q[digit_idx_q];
`ifdef SEG_LZB_EN
    if (lead_zero(disp_val_q, digit_idx_q)) begin
      seg_s = 7'h7F;
    end else begin
      seg_s = seg_decode(cur_bcd_s);
    end
`else
    seg_s = seg_decode(cur_bcd_s);
`endif
    frame_done_d = frame_end_s;
    if (scan_cnt_q == {CW{1'b0}}) begin
      result_d = 8'hFF;
      vcc_d    = 4'hF;
    end else begin
      result_d = {~cur_dp_s, seg_s};
      case (digit_idx_q)
        2'd0:    vcc_d = 4'hE;
        2'd1:    vcc_d = 4'hD;
        2'd2:    vcc_d = 4'hB;
        default: vcc_d = 4'h7;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge S_clk or posedge Reset) begin
    if (Reset) begin
      scan_cnt_q   <= {CW{1'b0}};
      digit_idx_q  <= 2'd0;
      disp_val_q   <= 16'h0000;
      disp_dp_q    <= 4'h0;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_valid_q <= 1'b0;
      result_q     <= 8'hFF;
      vcc_q        <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      digit_idx_q  <= digit_idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      result_q     <= result_d;
      vcc_q        <= vcc_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = !pend_valid_q;
  assign Result     = result_q;
  assign vcc_in     = vcc_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//   Self-checking bench for seg_scan_driver. Expected {frame_done, vcc_in,
//   Result} triples are queued one per clock edge when stimulus is applied
//   and popped against the DUT one edge at a time. A second instance with
//   SCAN_DIV=2 shares the clock and reset for the short-slot scan pattern.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  logic        S_clk;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [7:0]  Result;
  logic [3:0]  vcc_in;
  logic        frame_done;

  logic        iv2;
  logic        rdy2;
  logic [15:0] v2;
  logic [3:0]  d2;
  logic [7:0]  res2;
  logic [3:0]  vcc2;
  logic        fd2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] exp_q[$];

`ifdef SEG_LZB_EN
  localparam logic [7:0] ZL = 8'hFF;
`else
  localparam logic [7:0] ZL = 8'hC0;
`endif

  seg_scan_driver #(.SCAN_DIV(4)) dut (
    .S_clk(S_clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .value_in(value_in), .dp_in(dp_in), .Result(Result), .vcc_in(vcc_in),
    .frame_done(frame_done)
  );

  seg_scan_driver #(.SCAN_DIV(2)) dut2 (
    .S_clk(S_clk), .Reset(Reset), .in_valid(iv2), .in_ready(rdy2),
    .value_in(v2), .dp_in(d2), .Result(res2), .vcc_in(vcc2),
    .frame_done(fd2)
  );

  initial S_clk = 1'b0;
  always #5 S_clk = ~S_clk;

  task automatic tick();
    @(posedge S_clk);
    #1;
  endtask

  task automatic release_reset();
    Reset    = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge S_clk);
    Reset = 1'b0;
  endtask

  // Queue the 16 edges of one SCAN_DIV=4 frame showing codes c0..c3.
  task automatic push_frame(input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
    logic [7:0] codes[4];
    logic [3:0] an[4];
    codes = '{c0, c1, c2, c3};
    an    = '{4'hE, 4'hD, 4'hB, 4'h7};
    for (int k = 1; k <= 16; k++) begin
      int slot;
      int dig;
      slot = (k - 1) % 4;
      dig  = (k - 1) / 4;
      if (slot == 0) exp_q.push_back({1'b0, 4'hF, 8'hFF});
      else           exp_q.push_back({(k == 16) ? 1'b1 : 1'b0, an[dig], codes[dig]});
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; in_valid = 1'b0; value_in = 16'h0000; dp_in = 4'h0;
    #12;
    n_checks++; if (Result !== 8'hFF)   begin n_fail++; $display("FAIL reset_result got %h want ff", Result); end
    n_checks++; if (vcc_in !== 4'hF)    begin n_fail++; $display("FAIL reset_vcc got %h want f", vcc_in); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b want 0", frame_done); end
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_checks++; if (vcc2 !== 4'hF)      begin n_fail++; $display("FAIL reset_vcc2 got %h want f", vcc2); end
  endtask

  task automatic test_scan();
    logic [12:0] e;
    logic [3:0]  tab2[8];
    logic [7:0]  r2;
    tab2 = '{4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7};
    release_reset();
    push_frame(8'hC0, ZL, ZL, ZL);
    exp_q.push_back({1'b0, 4'hF, 8'hFF});
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL scan edge %0d scoreboard empty", k); end
      else begin
        e = exp_q.pop_front();
        if ({frame_done, vcc_in, Result} !== e) begin
          n_fail++;
          $display("FAIL scan edge %0d fd/vcc/seg got %b/%h/%h want %b/%h/%h",
                   k, frame_done, vcc_in, Result, e[12], e[11:8], e[7:0]);
        end
      end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL scan_ready edge %0d got %b want 1", k, in_ready); end
      n_checks++;
      if (vcc2 !== tab2[(k - 1) % 8]) begin
        n_fail++; $display("FAIL div2_vcc edge %0d got %h want %h", k, vcc2, tab2[(k - 1) % 8]);
      end
      n_checks++;
      if (fd2 !== ((k % 8) == 0)) begin
        n_fail++; $display("FAIL div2_fd edge %0d got %b want %b", k, fd2, (k % 8) == 0);
      end
      r2 = (((k - 1) % 2) == 0) ? 8'hFF : ((((k - 1) / 2) % 4) == 0 ? 8'hC0 : ZL);
      n_checks++;
      if (res2 !== r2) begin n_fail++; $display("FAIL div2_seg edge %0d got %h want %h", k, res2, r2); end
    end
  endtask

  task automatic test_single();
    logic [12:0] e;
    logic        rdy;
    release_reset();
    push_frame(8'hC0, ZL, ZL, ZL);
    for (int k = 1; k <= 32; k++) begin
      if (k == 3) begin
        in_valid = 1'b1; value_in = 16'h1234; dp_in = 4'b0010;
        push_frame(8'h99, 8'h30, 8'hA4, 8'hF9);
      end
      tick();
      if (k == 3) in_valid = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL single edge %0d scoreboard empty", k); end
      else begin
        e = exp_q.pop_front();
        if ({frame_done, vcc_in, Result} !== e) begin
          n_fail++;
          $display("FAIL single edge %0d fd/vcc/seg got %b/%h/%h want %b/%h/%h",
                   k, frame_done, vcc_in, Result, e[12], e[11:8], e[7:0]);
        end
      end
      rdy = !(k >= 3 && k <= 15);
      n_checks++;
      if (in_ready !== rdy) begin n_fail++; $display("FAIL single_ready edge %0d got %b want %b", k, in_ready, rdy); end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    logic        rdy;
    logic        acc;
    int          idx;
    release_reset();
    push_frame(8'hC0, ZL, ZL, ZL);
    in_valid = 1'b1; value_in = 16'h5678; dp_in = 4'b0001;
    push_frame(8'h00, 8'hF8, 8'h82, 8'h92);
    idx = 0;
    for (int k = 1; k <= 48; k++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        n_checks++;
        if (idx == 0) begin
          if (k != 1) begin n_fail++; $display("FAIL b2b_accept_a edge got %0d want 1", k); end
          value_in = 16'h9012; dp_in = 4'b1000;
          push_frame(8'hA4, 8'hF9, 8'hC0, 8'h10);
          idx = 1;
        end else begin
          if (k != 17) begin n_fail++; $display("FAIL b2b_accept_b edge got %0d want 17", k); end
          in_valid = 1'b0;
          idx = 2;
        end
      end
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b edge %0d scoreboard empty", k); end
      else begin
        e = exp_q.pop_front();
        if ({frame_done, vcc_in, Result} !== e) begin
          n_fail++;
          $display("FAIL b2b edge %0d fd/vcc/seg got %b/%h/%h want %b/%h/%h",
                   k, frame_done, vcc_in, Result, e[12], e[11:8], e[7:0]);
        end
      end
      rdy = !((k >= 1 && k <= 15) || (k >= 17 && k <= 31));
      n_checks++;
      if (in_ready !== rdy) begin n_fail++; $display("FAIL b2b_ready edge %0d got %b want %b", k, in_ready, rdy); end
    end
    n_checks++;
    if (idx != 2) begin n_fail++; $display("FAIL b2b_timeout accepted %0d want 2", idx); end
    in_valid = 1'b0;
  endtask

  task automatic test_lzb();
    logic [12:0] e;
    release_reset();
    push_frame(8'hC0, ZL, ZL, ZL);
    in_valid = 1'b1; value_in = 16'h00A5; dp_in = 4'h0;
    push_frame(8'h92, 8'hBF, ZL, ZL);
    for (int k = 1; k <= 32; k++) begin
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL lzb edge %0d scoreboard empty", k); end
      else begin
        e = exp_q.pop_front();
        if ({frame_done, vcc_in, Result} !== e) begin
          n_fail++;
          $display("FAIL lzb edge %0d fd/vcc/seg got %b/%h/%h want %b/%h/%h",
                   k, frame_done, vcc_in, Result, e[12], e[11:8], e[7:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    release_reset();
    push_frame(8'hC0, ZL, ZL, ZL);
    in_valid = 1'b1; value_in = 16'h1234; dp_in = 4'h0;
    push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
    for (int k = 1; k <= 26; k++) begin
      if (k == 20) begin in_valid = 1'b1; value_in = 16'h4321; dp_in = 4'hF; end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL rmid edge %0d scoreboard empty", k); end
      else begin
        e = exp_q.pop_front();
        if ({frame_done, vcc_in, Result} !== e) begin
          n_fail++;
          $display("FAIL rmid edge %0d fd/vcc/seg got %b/%h/%h want %b/%h/%h",
                   k, frame_done, vcc_in, Result, e[12], e[11:8], e[7:0]);
        end
      end
    end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_pending got ready %b want 0", in_ready); end
    Reset = 1'b1;
    #1;
    n_checks++; if (Result !== 8'hFF)    begin n_fail++; $display("FAIL rmid_result got %h want ff", Result); end
    n_checks++; if (vcc_in !== 4'hF)     begin n_fail++; $display("FAIL rmid_vcc got %h want f", vcc_in); end
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL rmid_ready got %b want 1", in_ready); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rmid_fd got %b want 0", frame_done); end
    release_reset();
    push_frame(8'hC0, ZL, ZL, ZL);
    push_frame(8'hC0, ZL, ZL, ZL);
    for (int k = 1; k <= 32; k++) begin
      tick();
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL rmid_after edge %0d scoreboard empty", k); end
      else begin
        e = exp_q.pop_front();
        if ({frame_done, vcc_in, Result} !== e) begin
          n_fail++;
          $display("FAIL rmid_after edge %0d fd/vcc/seg got %b/%h/%h want %b/%h/%h",
                   k, frame_done, vcc_in, Result, e[12], e[11:8], e[7:0]);
        end
      end
    end
  endtask

  initial begin
    iv2 = 1'b0; v2 = 16'h0000; d2 = 4'h0;
    test_reset();
    test_scan();
    test_single();
    test_back_to_back();
    test_lzb();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
